mem_stage_unit: RTL

Parametrised data-memory stage for the pipeline, successor to the single-select ROM/DMEM stage. Decodes each load/store address into one of four regions (ROM, internal DMEM, external MMIO, unmapped), performs byte-enabled writes, inserts per-region wait states, and returns one registered response per request. Sits between the execute stage (ALU result as address, register data as store data) and write-back, and holds the pipeline via `stall` while a multi-cycle access is in flight.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_if.sv | 26 ++
 rtl/dmem_bank.sv | 27 ++
 rtl/mem_stage_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the data-memory stage: address regions, FSM states, region decode.
// Pure declarations, no latency or backpressure of its own.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        REG_ROM  = 2'b00,
        REG_DMEM = 2'b01,
        REG_IO   = 2'b10,
        REG_NONE = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ROM_WT = 2'b01,
        IO_WT  = 2'b10
    } state_e;

    function automatic region_e decode_region(input logic [1:0] top_bits);
        case (top_bits)
            2'b00:   return REG_ROM;
            2'b01:   return REG_DMEM;
            2'b10:   return REG_IO;
            default: return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/response bus between execute and the memory stage.
// valid/ready on the request side; the response is a single pulse with no backpressure.
interface mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM with per-byte write enables; read-during-write returns old data.
// Read data valid one cycle after en_i; always accepts, no backpressure.
module dmem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic [DATA_W/8-1:0]      we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_stage_unit.sv
// Data-memory stage: region decode, byte-enabled DMEM, ROM wait states, MMIO with timeout.
// Latency 1 for DMEM/errors, ROM_WAIT+1 for ROM, ack+1 for MMIO; req_ready only in IDLE.
module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DMEM_DEPTH = 1024,
    parameter int ROM_WAIT   = 2,
    parameter int IO_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_stage_if.slave          bus,
    output logic                stall,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_rdata,
    output logic                io_req,
    output logic                io_we,
    output logic [DATA_W/8-1:0] io_be,
    output logic [ADDR_W-1:0]   io_addr,
    output logic [DATA_W-1:0]   io_wdata,
    input  logic                io_ack,
    input  logic [DATA_W-1:0]   io_rdata
);
    localparam int BE_W    = DATA_W / 8;
    localparam int OFF     = $clog2(BE_W);
    localparam int IDX_W   = $clog2(DMEM_DEPTH);
    localparam int CNT_MAX = (ROM_WAIT > IO_TIMEOUT) ? ROM_WAIT : IO_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                dmem_rd_q, dmem_rd_d;
    logic                io_req_q, io_req_d;
    logic                io_we_q, io_we_d;
    logic [BE_W-1:0]     io_be_q, io_be_d;
    logic [ADDR_W-1:0]   io_addr_q, io_addr_d;
    logic [DATA_W-1:0]   io_wdata_q, io_wdata_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;

    logic                accept;
    logic                misalign;
    region_e             region;
    logic                ram_en;
    logic [BE_W-1:0]     ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign region   = decode_region(bus.req_addr[ADDR_W-1 -: 2]);
    assign misalign = (bus.req_addr & ADDR_W'(BE_W - 1)) != '0;
    assign ram_en   = accept && (region == REG_DMEM) && !misalign;
    assign ram_we   = bus.req_we ? bus.req_be : '0;

    dmem_bank #(.DATA_W(DATA_W), .DEPTH(DMEM_DEPTH)) u_dmem (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (bus.req_addr[OFF +: IDX_W]),
        .wdata_i (bus.req_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        dmem_rd_d   = 1'b0;
        io_req_d    = io_req_q;
        io_we_d     = io_we_q;
        io_be_d     = io_be_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        rom_addr_d  = rom_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misalign || region == REG_NONE || (region == REG_ROM && bus.req_we)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        case (region)
                            REG_DMEM: begin
                                rsp_valid_d = 1'b1;
                                dmem_rd_d   = !bus.req_we;
                            end
                            REG_ROM: begin
                                rom_addr_d = bus.req_addr >> OFF;
                                cnt_d      = CNT_W'(ROM_WAIT - 1);
                                state_d    = ROM_WT;
                            end
                            default: begin
                                io_req_d   = 1'b1;
                                io_we_d    = bus.req_we;
                                io_be_d    = bus.req_be;
                                io_addr_d  = bus.req_addr;
                                io_wdata_d = bus.req_wdata;
                                cnt_d      = CNT_W'(1);
                                state_d    = IO_WT;
                            end
                        endcase
                    end
                end
            end
            ROM_WT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rom_rdata;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IO_WT: begin
                // Ack is checked first so an ack on the timeout cycle still completes cleanly.
                if (io_ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = io_we_q ? '0 : io_rdata;
                    io_req_d    = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_W'(IO_TIMEOUT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    io_req_d    = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            dmem_rd_q   <= 1'b0;
            io_req_q    <= 1'b0;
            io_we_q     <= 1'b0;
            io_be_q     <= '0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            rom_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            dmem_rd_q   <= dmem_rd_d;
            io_req_q    <= io_req_d;
            io_we_q     <= io_we_d;
            io_be_q     <= io_be_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            rom_addr_q  <= rom_addr_d;
        end
    end

    // DMEM load data comes straight from the RAM's output register.
    assign bus.rsp_rdata = dmem_rd_q ? ram_rdata : rsp_rdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.req_ready = (state_q == IDLE);
    assign stall         = (state_q != IDLE);
    assign rom_addr      = rom_addr_q;
    assign io_req        = io_req_q;
    assign io_we         = io_we_q;
    assign io_be         = io_be_q;
    assign io_addr       = io_addr_q;
    assign io_wdata      = io_wdata_q;
endmodule
